spawn_ctrl: RTL
===============

SPAWN_CTRL -- requirements
Module: spawn_ctrl

Interface
REQ-001 Parameter X_MAX, default 160, exclusive upper bound of spawn_x (legal range 1..255).
REQ-002 Parameter MAX_TRIES, default 8, rejection-sampling attempts before fallback (legal range 1..15).
REQ-003 Parameter FALLBACK_X, default 80, spawn_x used when all attempts reject (must be < X_MAX).
REQ-004 Parameter COOLDOWN, default 60, idle cycles after each accepted spawn (legal range 1..255).
REQ-005 Clk  input  1  sole clock, all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 rand_num  input  8  pseudo-random byte from the upstream random generator, new value every cycle.
REQ-008 enable  input  1  permits a new spawn draw to start.
REQ-009 spawn_ready  input  1  downstream consumer accepts the offered spawn.
REQ-010 spawn_valid  output  1  spawn_x/spawn_kind hold a valid offer.
REQ-011 spawn_x  output  8  spawn column, always < X_MAX when spawn_valid=1.
REQ-012 spawn_kind  output  2  spawn object type.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 spawn_count  output  8  count of completed handshakes.

Function
REQ-015 The FSM SHALL have the states IDLE, DRAW_X, DRAW_KIND, OFFER and COOL.
REQ-016 IDLE: if enable=1, go to DRAW_X next cycle and clear the try counter; otherwise stay in IDLE.
REQ-017 DRAW_X: if rand_num < X_MAX, latch rand_num into spawn_x and go to DRAW_KIND.
REQ-018 DRAW_X with rand_num >= X_MAX: increment the try counter and stay; on the MAX_TRIES-th rejection, latch FALLBACK_X instead and go to DRAW_KIND.
REQ-019 DRAW_KIND: latch rand_num[1:0] into spawn_kind (value one cycle after the x draw), then go to OFFER.
REQ-020 OFFER: spawn_valid=1, with spawn_x and spawn_kind held stable until the cycle in which spawn_ready=1.
REQ-021 A handshake is spawn_valid=1 and spawn_ready=1 on the same edge; on that edge go to COOL, load the cooldown counter with COOLDOWN-1 and increment spawn_count.
REQ-022 spawn_count SHALL wrap from 255 to 0.
REQ-023 COOL: decrement the counter each cycle; move to IDLE on the cycle the counter is 0, giving exactly COOLDOWN cycles in COOL.
REQ-024 enable is sampled only in IDLE; deasserting it during DRAW_X, DRAW_KIND, OFFER or COOL SHALL NOT abort the sequence.
REQ-025 spawn_ready is ignored outside OFFER; spawn_valid SHALL be 0 in every state except OFFER.
REQ-026 Minimum latency: enable high in IDLE at cycle N gives spawn_valid=1 at cycle N+3 (accept on first draw).

Reset
REQ-027 Reset=1 SHALL force on the next edge: state=IDLE, spawn_valid=0, spawn_x=0, spawn_kind=0, busy=0, spawn_count=0, try counter=0, cooldown counter=0.
REQ-028 Reset SHALL take priority over every other input, including a handshake on the same edge (spawn_count stays 0).
REQ-029 Reset asserted mid-OFFER or mid-COOL SHALL discard the pending offer or cooldown with no partial output.

Structure
REQ-030 Package spawn_pkg SHALL hold the FSM state enum and the default values of X_MAX, MAX_TRIES, FALLBACK_X and COOLDOWN.
REQ-031 The cooldown logic SHALL be one sub-module, down_counter (load, decrement, zero flag); the random generator is instantiated outside spawn_ctrl and connected via rand_num.

Verification
REQ-032 Defaults, enable=1, rand_num=0x40 during DRAW_X, 0x03 during DRAW_KIND -> spawn_valid=1 at N+3 with spawn_x=0x40, spawn_kind=3.
REQ-033 rand_num held at 0xC8 (200 >= 160) -> 8 DRAW_X cycles, then spawn_x=80 (FALLBACK_X) and spawn_valid=1 two cycles later.
REQ-034 spawn_ready low for 5 cycles of OFFER while rand_num varies -> spawn_x/spawn_kind unchanged; handshake on cycle 6 -> spawn_count=1.
REQ-035 COOLDOWN=4, handshake at edge H, enable=1 throughout -> COOL for H+1..H+4, IDLE at H+5, DRAW_X at H+6, busy=0 only at H+5.
REQ-036 Reset=1 on a handshake edge during OFFER -> next cycle spawn_valid=0, state IDLE, spawn_count=0.
REQ-037 256 consecutive handshakes (COOLDOWN=1, spawn_ready=1) -> spawn_count reads 0 after the 256th.

Source files
------------

// File: rtl/spawn_pkg.sv
// Shared types and default parameter values for the spawn controller.
package spawn_pkg;
    typedef enum logic [2:0] {IDLE, DRAW_X, DRAW_KIND, OFFER, COOL} state_e;

    localparam int X_MAX_DEF      = 160;
    localparam int MAX_TRIES_DEF  = 8;
    localparam int FALLBACK_X_DEF = 80;
    localparam int COOLDOWN_DEF   = 60;
endpackage

// File: rtl/spawn_if.sv
// Spawn offer bus: random input, enable, valid/ready offer and status.
interface spawn_if;
    logic [7:0] rand_num;
    logic       enable;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [7:0] spawn_x;
    logic [1:0] spawn_kind;
    logic       busy;
    logic [7:0] spawn_count;

    modport master (
        output rand_num, enable, spawn_ready,
        input  spawn_valid, spawn_x, spawn_kind, busy, spawn_count
    );
    modport slave (
        input  rand_num, enable, spawn_ready,
        output spawn_valid, spawn_x, spawn_kind, busy, spawn_count
    );
endinterface

// File: rtl/down_counter.sv
// Loadable down counter with zero flag; saturates at zero.
module down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)                    cnt_d = load_val;
        else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/spawn_ctrl.sv
// Spawn controller: rejection-samples a column, draws a kind, offers it
// on a valid/ready handshake, then idles for a fixed cooldown.
module spawn_ctrl
    import spawn_pkg::*;
#(
    parameter int X_MAX      = X_MAX_DEF,
    parameter int MAX_TRIES  = MAX_TRIES_DEF,
    parameter int FALLBACK_X = FALLBACK_X_DEF,
    parameter int COOLDOWN   = COOLDOWN_DEF
) (
    input  logic   clk,
    input  logic   reset,
    spawn_if.slave bus
);
    localparam logic [7:0] XM       = 8'(X_MAX);
    localparam logic [7:0] FB_X     = 8'(FALLBACK_X);
    localparam logic [7:0] CD_LOAD  = 8'(COOLDOWN - 1);
    localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [1:0] kind_q, kind_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic [7:0] count_q, count_d;
    logic [3:0] try_q, try_d;
    logic       hs, cd_dec, cd_zero;

    assign hs = (state_q == OFFER) && bus.spawn_ready;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        kind_d  = kind_q;
        count_d = count_q;
        try_d   = try_q;
        cd_dec  = 1'b0;
        case (state_q)
            IDLE: if (bus.enable) begin
                state_d = DRAW_X;
                try_d   = '0;
            end
            DRAW_X: begin
                if (bus.rand_num < XM) begin
                    x_d     = bus.rand_num;
                    state_d = DRAW_KIND;
                end else if (try_q == TRY_LAST) begin
                    // out of attempts: use the fixed column
                    x_d     = FB_X;
                    state_d = DRAW_KIND;
                end else begin
                    try_d = try_q + 4'd1;
                end
            end
            DRAW_KIND: begin
                kind_d  = bus.rand_num[1:0];
                state_d = OFFER;
            end
            OFFER: if (hs) begin
                state_d = COOL;
                count_d = count_q + 8'd1;
            end
            COOL: begin
                if (cd_zero) state_d = IDLE;
                else         cd_dec  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == OFFER);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            kind_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            try_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            kind_q  <= kind_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            count_q <= count_d;
            try_q   <= try_d;
        end
    end

    down_counter #(.W(8)) u_cool (
        .clk      (clk),
        .reset    (reset),
        .load     (hs),
        .dec      (cd_dec),
        .load_val (CD_LOAD),
        .zero     (cd_zero)
    );

    assign bus.spawn_valid = valid_q;
    assign bus.spawn_x     = x_q;
    assign bus.spawn_kind  = kind_q;
    assign bus.busy        = busy_q;
    assign bus.spawn_count = count_q;
endmodule
